// File: rtl/apb_timer_bank.sv
`default_nettype none
// ============================================================================
// apb_timer_bank: NUM_CH prescaled up-counting timers behind one APB slave.
// Revision: 1.0
// ============================================================================
module apb_timer_bank #(
  parameter int NUM_CH    = 4,
  parameter int WIDTH     = 16,
  parameter int BASE_ADDR = 0,
  parameter int ADDR_W    = 6,
  parameter int PRESC_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [WIDTH-1:0]  pwdata,
  output logic [WIDTH-1:0]  prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [NUM_CH-1:0] irq,
  output logic              irq_any
);

  localparam int PRESC_OFS = 4 * NUM_CH;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } apb_state_t;

  apb_state_t state, state_nxt;
  logic       access, start, commit;

  assign access = psel & penable;

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // First ACCESS cycle arms ST_ACK; the edge ending ST_ACK commits the write.
  always_comb begin
    state_nxt = state;
    pready    = 1'b0;
    start     = 1'b0;
    commit    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (access) begin
          start     = 1'b1;
          state_nxt = ST_ACK;
        end
      end
      ST_ACK: begin
        pready    = 1'b1;
        commit    = access;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  logic [31:0] addr_ext, offset;
  logic [29:0] ch_sel;
  logic [1:0]  reg_sel;
  logic        in_map, is_presc, err, wr_en;

  assign addr_ext = 32'(paddr);
  assign offset   = addr_ext - 32'(BASE_ADDR);
  assign in_map   = (addr_ext >= 32'(BASE_ADDR)) && (offset <= 32'(PRESC_OFS));
  assign is_presc = (offset == 32'(PRESC_OFS));
  assign ch_sel   = offset[31:2];
  assign reg_sel  = offset[1:0];
  assign err      = !in_map || (!is_presc && pwrite && reg_sel == 2'd2);
  assign wr_en    = commit && pwrite && !err;

  logic [PRESC_W-1:0] presc, presc_cnt;
  logic               tick, presc_wr;

  assign tick     = (presc_cnt == presc);
  assign presc_wr = wr_en && is_presc;

  always_ff @(posedge clk) begin
    if (!reset) begin
      presc     <= '0;
      presc_cnt <= '0;
    end else if (presc_wr) begin
      presc     <= pwdata[PRESC_W-1:0];
      presc_cnt <= '0;
    end else begin
      presc_cnt <= tick ? '0 : presc_cnt + PRESC_W'(1);
    end
  end

  logic [WIDTH-1:0]  rd_ctrl  [NUM_CH];
  logic [WIDTH-1:0]  rd_load  [NUM_CH];
  logic [WIDTH-1:0]  rd_count [NUM_CH];
  logic [WIDTH-1:0]  rd_stat  [NUM_CH];
  logic [NUM_CH-1:0] irq_set;

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    logic             en, pause, mode, irq_en, done;
    logic [WIDTH-1:0] load, count;
    logic             hit, ctrl_wr, load_wr, stat_wr, run, match;

    assign hit     = wr_en && !is_presc && (ch_sel == 30'(n));
    assign ctrl_wr = hit && (reg_sel == 2'd0);
    assign load_wr = hit && (reg_sel == 2'd1);
    assign stat_wr = hit && (reg_sel == 2'd3);
    assign run     = tick && en && !pause;
    assign match   = (count == load);

    always_ff @(posedge clk) begin
      if (!reset) begin
        en     <= 1'b0;
        pause  <= 1'b0;
        mode   <= 1'b0;
        irq_en <= 1'b0;
        done   <= 1'b0;
        load   <= '0;
        count  <= '0;
      end else begin
        // A CTRL write owns EN and COUNT on its edge; a coincident tick is dropped.
        if (ctrl_wr) begin
          en     <= pwdata[0];
          pause  <= pwdata[1];
          mode   <= pwdata[2];
          irq_en <= pwdata[3];
          if (!pwdata[0] || !en) count <= '0;
        end else if (run) begin
          if (match) begin
            if (mode) count <= '0;
            else      en    <= 1'b0;
          end else begin
            count <= count + WIDTH'(1);
          end
        end
        if (load_wr) load <= pwdata;
        done <= (run && match) || (done && !(stat_wr && pwdata[0]));
      end
    end

    assign irq_set[n]  = done && irq_en;
    assign rd_ctrl[n]  = {{(WIDTH-4){1'b0}}, irq_en, mode, pause, en};
    assign rd_load[n]  = load;
    assign rd_count[n] = count;
    assign rd_stat[n]  = {{(WIDTH-2){1'b0}}, en && !pause, done};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      irq     <= '0;
      irq_any <= 1'b0;
    end else begin
      irq     <= irq_set;
      irq_any <= |irq_set;
    end
  end

  logic [WIDTH-1:0] rd_data;

  always_comb begin
    rd_data = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      if (ch_sel == 30'(n)) begin
        case (reg_sel)
          2'd0:    rd_data = rd_ctrl[n];
          2'd1:    rd_data = rd_load[n];
          2'd2:    rd_data = rd_count[n];
          default: rd_data = rd_stat[n];
        endcase
      end
    end
    if (is_presc) rd_data = WIDTH'(presc);
    if (err)      rd_data = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      prdata  <= '0;
      pslverr <= 1'b0;
    end else if (start) begin
      prdata  <= pwrite ? '0 : rd_data;
      pslverr <= err;
    end else begin
      prdata  <= '0;
      pslverr <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_timer_bank.sv
`default_nettype none
// tb_apb_timer_bank: directed APB vectors against a 16-bit and an 8-bit bank.
module tb_apb_timer_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        psel_a, psel_b, penable, pwrite;
  logic [5:0]  paddr;
  logic [15:0] pwdata;
  logic [15:0] prdata_a;
  logic        pready_a, pslverr_a, irq_any_a;
  logic [3:0]  irq_a;
  logic [7:0]  prdata_b;
  logic        pready_b, pslverr_b, irq_any_b;
  logic [3:0]  irq_b;

  apb_timer_bank #(.NUM_CH(4), .WIDTH(16), .BASE_ADDR(0), .ADDR_W(6), .PRESC_W(8)) dut (
    .clk(clk), .reset(reset), .psel(psel_a), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata_a), .pready(pready_a),
    .pslverr(pslverr_a), .irq(irq_a), .irq_any(irq_any_a)
  );

  apb_timer_bank #(.NUM_CH(4), .WIDTH(8), .BASE_ADDR(0), .ADDR_W(6), .PRESC_W(8)) dut8 (
    .clk(clk), .reset(reset), .psel(psel_b), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata[7:0]), .prdata(prdata_b), .pready(pready_b),
    .pslverr(pslverr_b), .irq(irq_b), .irq_any(irq_any_b)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int cap_edge, commit_edge;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Entered and left #1 after a rising edge; the data is captured at cap_edge
  // from register state after cap_edge-1, and a write lands on commit_edge.
  task automatic xfer(input bit b, input bit wr, input int a, input int d,
                      output int rd, output bit err);
    int waits;
    paddr   = 6'(a);
    pwrite  = wr;
    pwdata  = 16'(d);
    psel_a  = !b;
    psel_b  = b;
    penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    waits   = 0;
    while (!(b ? pready_b : pready_a) && waits < 8) begin
      @(posedge clk); #1;
      waits++;
    end
    cap_edge = cyc;
    check("wait_states", 32'(waits), 32'd1);
    rd  = b ? int'(prdata_b) : int'(prdata_a);
    err = b ? pslverr_b : pslverr_a;
    @(posedge clk); #1;
    commit_edge = cyc;
    psel_a  = 1'b0;
    psel_b  = 1'b0;
    penable = 1'b0;
  endtask

  task automatic wr(input bit b, input int a, input int d);
    int r; bit e;
    xfer(b, 1'b1, a, d, r, e);
    check("wr_err", 32'(e), 32'd0);
  endtask

  task automatic rd_chk(input bit b, input string tag, input int a, input int exp);
    int r; bit e;
    xfer(b, 1'b0, a, 0, r, e);
    check(tag, 32'(r), 32'(exp));
    check({tag, "_err"}, 32'(e), 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Tick edges with PRESC=1 written at edge p fall on p+2, p+4, ...; count those in (a,b].
  function automatic int tk(input int p, input int a, input int b);
    return (b - p) / 2 - (a - p) / 2;
  endfunction

  // 8-bit channel: 9 at edge u, then +1 per edge, matching LOAD=5 after the wrap.
  function automatic int cnt8(input int n);
    return (n >= 253) ? 5 : (9 + n) % 256;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, v1, p, e0, e2, x, y, u, n, guard;
    bit e;
    reset = 1'b0; psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0;
    pwrite = 1'b0; paddr = '0; pwdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pready", 32'(pready_a), 32'd0);
    check("rst_pslverr", 32'(pslverr_a), 32'd0);
    check("rst_prdata", 32'(prdata_a), 32'd0);
    check("rst_irq", 32'(irq_a), 32'd0);
    check("rst_irq_any", 32'(irq_any_a), 32'd0);
    reset = 1'b1;
    idle(1);

    for (int a = 0; a <= 16; a++) rd_chk(1'b0, "rst_read", a, 0);
    xfer(1'b0, 1'b0, 17, 0, r, e);
    check("oob_err", 32'(e), 32'd1);
    check("oob_data", 32'(r), 32'd0);
    xfer(1'b0, 1'b0, 63, 0, r, e);
    check("oob63_err", 32'(e), 32'd1);

    // ch0 one-shot with interrupt, tick every cycle
    wr(1'b0, 1, 3);
    wr(1'b0, 16, 0);
    wr(1'b0, 0, 'b1001);
    n = 0;
    while (!irq_a[0] && n < 20) begin @(posedge clk); #1; n++; end
    check("ch0_irq_delay", 32'(n), 32'd5);
    check("ch0_irq_vec", 32'(irq_a), 32'd1);
    check("ch0_irq_any", 32'(irq_any_a), 32'd1);
    rd_chk(1'b0, "ch0_count", 2, 3);
    rd_chk(1'b0, "ch0_status", 3, 1);
    rd_chk(1'b0, "ch0_ctrl", 0, 'b1000);

    // ch1 auto-reload, PRESC=1
    wr(1'b0, 16, 1);
    p = commit_edge;
    wr(1'b0, 5, 2);
    wr(1'b0, 4, 'b1101);
    e0 = commit_edge;
    xfer(1'b0, 1'b0, 7, 0, r, e);
    check("ch1_status0", 32'(r), 32'(2 | ((tk(p, e0, cap_edge - 1) >= 3) ? 1 : 0)));
    for (int i = 0; i < 6; i++) begin
      xfer(1'b0, 1'b0, 6, 0, r, e);
      check("ch1_count", 32'(r), 32'(tk(p, e0, cap_edge - 1) % 3));
    end
    rd_chk(1'b0, "ch1_status1", 7, 3);
    check("ch1_irq_on", 32'(irq_a[1]), 32'd1);
    wr(1'b0, 4, 'b1111);
    wr(1'b0, 7, 1);
    idle(1);
    check("ch1_irq_off", 32'(irq_a[1]), 32'd0);
    check("ch1_irq_any_ch0", 32'(irq_any_a), 32'd1);
    rd_chk(1'b0, "ch1_status_clr", 7, 0);
    wr(1'b0, 4, 0);

    // ch2 pause / resume, COUNT write rejected
    wr(1'b0, 9, 1000);
    wr(1'b0, 8, 1);
    e2 = commit_edge;
    idle(20);
    wr(1'b0, 8, 'b0011);
    x = commit_edge;
    xfer(1'b0, 1'b0, 10, 0, v1, e);
    check("ch2_frozen", 32'(v1), 32'(tk(p, e2, x - 1)));
    idle(10);
    rd_chk(1'b0, "ch2_still", 10, v1);
    rd_chk(1'b0, "ch2_status_paused", 11, 0);
    wr(1'b0, 8, 1);
    y = commit_edge;
    xfer(1'b0, 1'b0, 10, 0, r, e);
    check("ch2_resume", 32'(r), 32'(v1 + tk(p, y, cap_edge - 1)));
    xfer(1'b0, 1'b1, 10, 'hABCD, r, e);
    check("ch2_count_wr_err", 32'(e), 32'd1);
    xfer(1'b0, 1'b0, 10, 0, r, e);
    check("ch2_after_wr", 32'(r), 32'(v1 + tk(p, y, cap_edge - 1)));

    // W1C coinciding with a ch0 match: set wins
    wr(1'b0, 16, 0);
    wr(1'b0, 3, 1);
    rd_chk(1'b0, "ch0_cleared", 3, 0);
    wr(1'b0, 1, 2);
    wr(1'b0, 0, 'b1101);
    wr(1'b0, 3, 1);
    rd_chk(1'b0, "w1c_vs_set", 3, 3);
    idle(2);
    check("pre_reset_irq0", 32'(irq_a[0]), 32'd1);

    // reset during a count and a transfer
    paddr = 6'd12; pwrite = 1'b1; pwdata = 16'd1; psel_a = 1'b1; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    reset   = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_pready", 32'(pready_a), 32'd0);
    check("mid_rst_pslverr", 32'(pslverr_a), 32'd0);
    check("mid_rst_prdata", 32'(prdata_a), 32'd0);
    check("mid_rst_irq", 32'(irq_a), 32'd0);
    check("mid_rst_irq_any", 32'(irq_any_a), 32'd0);
    psel_a = 1'b0; penable = 1'b0; reset = 1'b1;
    idle(1);
    for (int a = 0; a <= 16; a++) rd_chk(1'b0, "post_rst_read", a, 0);

    // 8-bit bank: LOAD below COUNT must wrap before completing
    wr(1'b1, 16, 255);
    wr(1'b1, 1, 200);
    wr(1'b1, 0, 1);
    r = 0; guard = 0;
    while (r != 9 && guard < 1500) begin
      xfer(1'b1, 1'b0, 2, 0, r, e);
      guard++;
    end
    check("w8_reach9", 32'(r), 32'd9);
    wr(1'b1, 0, 'b0011);
    rd_chk(1'b1, "w8_frozen", 2, 9);
    wr(1'b1, 1, 5);
    wr(1'b1, 16, 0);
    wr(1'b1, 0, 1);
    u = commit_edge;
    xfer(1'b1, 1'b0, 3, 0, r, e);
    check("w8_status_early", 32'(r), 32'((cap_edge - 1 - u >= 253) ? 1 : 2));
    xfer(1'b1, 1'b0, 2, 0, r, e);
    check("w8_count_a", 32'(r), 32'(cnt8(cap_edge - 1 - u)));
    idle(150);
    xfer(1'b1, 1'b0, 2, 0, r, e);
    check("w8_count_b", 32'(r), 32'(cnt8(cap_edge - 1 - u)));
    idle(88);
    xfer(1'b1, 1'b0, 2, 0, r, e);
    check("w8_count_wrap", 32'(r), 32'(cnt8(cap_edge - 1 - u)));
    xfer(1'b1, 1'b0, 3, 0, r, e);
    check("w8_status_mid", 32'(r), 32'((cap_edge - 1 - u >= 253) ? 1 : 2));
    idle(20);
    rd_chk(1'b1, "w8_status_done", 3, 1);
    rd_chk(1'b1, "w8_count_done", 2, 5);
    rd_chk(1'b1, "w8_ctrl_done", 0, 0);
    check("w8_irq_masked", 32'(irq_b), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
